iob_eth_rx_ring: RTL and testbench
==================================

Name: iob_eth_rx_ring

Overview:
- Parametrised MII receive engine for the Ethernet core: assembles nibbles into bytes, detects the SFD, filters on destination MAC, writes frames into an NSLOTS-deep ring of frame buffers, and checks the FCS.
- Per-frame status (slot, length, CRC result, errors) is reported on a single-cycle pulse.
- The consumer frees slots through a release handshake, so several frames can be buffered at once.
- Sits between the PHY RX pins and the dual-port RX buffer RAM; all logic is in the RX_CLK domain.

Parameters:
- BUF_AW, 11, byte-address width of one slot; slot capacity is 2^BUF_AW bytes.
- NSLOTS, 4, number of frame slots; power of two, at least 2.
- SLOT_W, $clog2(NSLOTS), slot index width (derived; not to be overridden).

Ports:
- RX_CLK  in  1  PHY receive clock; all logic on the rising edge.
- rx_rstn  in  1  reset, asynchronous, active-low.
- RX_DV  in  1  MII receive data valid.
- RX_DATA  in  4  MII nibble, low nibble first.
- mac_addr  in  48  station address; first byte on the wire is mac_addr[47:40].
- promisc  in  1  1 = accept any destination address.
- buf_addr  out  SLOT_W+BUF_AW  buffer RAM write address {slot, byte_idx}.
- buf_data  out  8  buffer RAM write data.
- buf_wr  out  1  buffer RAM write strobe.
- frame_done  out  1  one-cycle pulse: frame stored and slot committed.
- frame_slot  out  SLOT_W  slot of the committed frame; valid with frame_done.
- frame_len  out  BUF_AW+1  stored byte count, FCS included; valid with frame_done.
- frame_crc_ok  out  1  FCS residue matched; valid with frame_done.
- frame_err  out  1  alignment or overflow error; valid with frame_done.
- release  in  1  one-cycle pulse: consumer frees the oldest committed slot.
- slots_used  out  SLOT_W+1  number of committed, unreleased slots.
- drop_cnt  out  16  frames dropped because the ring was full; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, write and read slot pointers 0. Reset mid-frame aborts the frame; no frame_done is issued.
- Byte assembly: nibble phase toggles on each RX_DV=1 cycle. A byte is {second nibble, first nibble}, valid on the cycle after the second nibble. The phase clears when RX_DV=0.
- FSM states: IDLE, PREAMBLE, DEST, DATA, DROP, DONE.
- IDLE -> PREAMBLE on RX_DV=1.
- PREAMBLE: stay until an assembled byte equals 8'hD5. Then:
  - ring full (slots_used==NSLOTS): go to DROP, drop_cnt+1.
  - otherwise: go to DEST, byte_idx=0, CRC cleared.
- DEST: write 6 bytes. After the 6th, compare to mac_addr.
  - Match, or promisc=1: go to DATA.
  - Otherwise: go to DROP; the slot is not committed and drop_cnt is unchanged.
- DATA: write each byte, byte_idx+1.
  - If byte_idx would reach 2^BUF_AW: stop writing, set overflow, keep receiving for the CRC.
  - RX_DV=0: go to DONE. If it falls with an odd nibble pending, set align error.
- DONE: one cycle.
  - frame_done=1, frame_len=byte count, frame_crc_ok=(crc==32'hC704DD7B).
  - frame_err=overflow|align.
  - Write pointer +1 mod NSLOTS; back to IDLE.
- DROP: no writes; return to IDLE when RX_DV=0.
- buf_wr is high on the same cycle as the assembled byte; buf_addr={wr_slot, byte_idx}. Latency is 1 RX_CLK from the second nibble to buf_wr.
- slots_used: +1 on DONE, -1 on release.
  - DONE and release in the same cycle: unchanged.
  - release when slots_used==0: ignored.
- Frames shorter than 6 bytes after SFD: no frame_done; the slot is reused.

Optional Feature:
- Macro IOB_ETH_RX_BCAST_EN.
- Defined: destination FF:FF:FF:FF:FF:FF is accepted even when promisc=0.
- Undefined: broadcast frames are accepted only when promisc=1.

Decomposition:
- Package iob_eth_rx_pkg holds:
  - FSM state encodings.
  - ETH_SFD=8'hD5.
  - ETH_CRC_RESIDUE=32'hC704DD7B.
  - ETH_BCAST=48'hFFFFFFFFFFFF.
  - MAC_LEN=6.
- Sub-module: existing iob_eth_crc, instanced once. Connections: start on the SFD, data_en=buf_wr or overflow-byte valid, data_in=assembled byte.

Test Plan:
- Matching frame: mac 00:11:22:33:44:55, 46-byte payload plus valid FCS.
  - Expect frame_done, frame_slot=0, frame_len=56, crc_ok=1, err=0.
  - Expect 56 buf_wr pulses at addresses 0..55.
- Same frame with one payload bit flipped -> frame_done, crc_ok=0.
- Destination 00:11:22:33:44:56, promisc=0 -> no frame_done, slots_used stays 0, drop_cnt=0.
- Ring saturation: 5 frames back-to-back, NSLOTS=4, no release.
  - Expect 4 frame_done pulses on slots 0,1,2,3 and drop_cnt=1.
  - Then one release -> slots_used=3; the next frame goes to slot 0.
- release coincident with DONE at slots_used=2 -> slots_used stays 2.
- Odd nibble count at end of frame -> frame_err=1.
- rx_rstn low mid-DATA -> all outputs 0, no frame_done.
- BCAST_EN defined, broadcast destination, promisc=0 -> frame accepted.

Source files
------------

// File: rtl/iob_eth_rx_pkg.sv
// iob_eth_rx_pkg: shared FSM encoding, Ethernet constants and the byte-wise CRC-32 step.
package iob_eth_rx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DEST, S_DATA, S_DROP, S_DONE} rx_state_t;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [47:0] ETH_BCAST       = 48'hFFFFFFFFFFFF;
  localparam int          MAC_LEN         = 6;
  // Reflected CRC-32, one byte consumed LSB first as it appears on the wire.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ ETH_CRC_POLY : r >> 1;
    return r;
  endfunction
endpackage

// File: rtl/iob_eth_crc.sv
// iob_eth_crc: running Ethernet CRC-32; crc_o is bit-reversed so a good frame leaves ETH_CRC_RESIDUE.
module iob_eth_crc
  import iob_eth_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        data_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] crc_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) crc_q <= '1;
    else if (start_i) crc_q <= '1;
    else if (data_en_i) crc_q <= crc_byte(crc_q, data_i);
  always_comb
    for (int i = 0; i < 32; i++) crc_o[i] = crc_q[31-i];
endmodule

// File: rtl/iob_eth_rx_ring.sv
// iob_eth_rx_ring: MII receive engine writing frames into an NSLOTS-deep ring of buffer slots.
// Define IOB_ETH_RX_BCAST_EN to accept the broadcast destination without promisc.
module iob_eth_rx_ring
  import iob_eth_rx_pkg::*;
#(
  parameter  int BUF_AW = 11,
  parameter  int NSLOTS = 4,
  localparam int SLOT_W = $clog2(NSLOTS)
) (
  input  logic                     RX_CLK,
  input  logic                     rx_rstn,
  input  logic                     RX_DV,
  input  logic [3:0]               RX_DATA,
  input  logic [47:0]              mac_addr,
  input  logic                     promisc,
  output logic [SLOT_W+BUF_AW-1:0] buf_addr,
  output logic [7:0]               buf_data,
  output logic                     buf_wr,
  output logic                     frame_done,
  output logic [SLOT_W-1:0]        frame_slot,
  output logic [BUF_AW:0]          frame_len,
  output logic                     frame_crc_ok,
  output logic                     frame_err,
  input  logic                     release_i,
  output logic [SLOT_W:0]          slots_used,
  output logic [15:0]              drop_cnt
);
  rx_state_t         state_q, state_d;
  logic              phase_q, bvld_q;
  logic [3:0]        nib_q;
  logic [7:0]        byte_q;
  logic [BUF_AW:0]   cnt_q, cnt_d;
  logic [47:0]       dst_q, dst_d, dst_n;
  logic              ovf_q, ovf_d, aln_q, aln_d;
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W:0]   used_q, used_d;
  logic [15:0]       drop_q, drop_d;
  logic [31:0]       crc;
  logic              in_frame, crc_en, full, sfd, done, rel_ok, bcast, dst_ok;

  assign in_frame = state_q == S_DEST || state_q == S_DATA;
  assign crc_en   = bvld_q && in_frame;
  // cnt_q[BUF_AW] set means the slot is full; later bytes only feed the CRC
  assign buf_wr   = crc_en && !cnt_q[BUF_AW];
  assign full     = used_q == (SLOT_W+1)'(NSLOTS);
  assign sfd      = state_q == S_PRE && bvld_q && byte_q == ETH_SFD;
  assign done     = state_q == S_DONE;
  assign rel_ok   = release_i && used_q != '0;
  assign dst_n    = {dst_q[39:0], byte_q};
`ifdef IOB_ETH_RX_BCAST_EN
  assign bcast    = dst_n == ETH_BCAST;
`else
  assign bcast    = 1'b0;
`endif
  assign dst_ok   = dst_n == mac_addr || promisc || bcast;

  iob_eth_crc u_crc (
    .clk_i    (RX_CLK),
    .rstn_i   (rx_rstn),
    .start_i  (sfd),
    .data_en_i(crc_en),
    .data_i   (byte_q),
    .crc_o    (crc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + (BUF_AW+1)'(buf_wr);
    dst_d     = (bvld_q && state_q == S_DEST) ? dst_n : dst_q;
    ovf_d     = ovf_q | (crc_en && cnt_q[BUF_AW]);
    aln_d     = aln_q;
    drop_d    = drop_q;
    wr_slot_d = wr_slot_q + SLOT_W'(done);
    used_d    = used_q + (SLOT_W+1)'(done) - (SLOT_W+1)'(rel_ok);
    case (state_q)
      S_IDLE: state_d = RX_DV ? S_PRE : S_IDLE;
      S_PRE:
        if (sfd) begin
          state_d = full ? S_DROP : S_DEST;
          drop_d  = drop_q + 16'(full && !(&drop_q));
          cnt_d   = '0;
          ovf_d   = 1'b0;
          aln_d   = 1'b0;
        end else if (!RX_DV) state_d = S_IDLE;
      S_DEST:
        if (bvld_q && cnt_q == (BUF_AW+1)'(MAC_LEN - 1)) state_d = dst_ok ? S_DATA : S_DROP;
        else if (!RX_DV) state_d = S_IDLE;
      S_DATA:
        if (!RX_DV) begin
          state_d = S_DONE;
          aln_d   = phase_q;
        end
      S_DROP:  state_d = RX_DV ? S_DROP : S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rx_rstn)
    if (!rx_rstn) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      bvld_q    <= 1'b0;
      nib_q     <= '0;
      byte_q    <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
      ovf_q     <= 1'b0;
      aln_q     <= 1'b0;
      wr_slot_q <= '0;
      used_q    <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= RX_DV && !phase_q;
      bvld_q    <= RX_DV && phase_q;
      if (RX_DV && !phase_q) nib_q <= RX_DATA;
      if (RX_DV && phase_q) byte_q <= {RX_DATA, nib_q};
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
      ovf_q     <= ovf_d;
      aln_q     <= aln_d;
      wr_slot_q <= wr_slot_d;
      used_q    <= used_d;
      drop_q    <= drop_d;
    end

  assign buf_addr     = {wr_slot_q, cnt_q[BUF_AW-1:0]};
  assign buf_data     = byte_q;
  assign frame_done   = done;
  assign frame_slot   = done ? wr_slot_q : '0;
  assign frame_len    = done ? cnt_q : '0;
  assign frame_crc_ok = done && crc == ETH_CRC_RESIDUE;
  assign frame_err    = done && (ovf_q || aln_q);
  assign slots_used   = used_q;
  assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_iob_eth_rx_ring.sv
// tb_iob_eth_rx_ring: randomized frames checked against a frame-level model of the receive ring.
module tb_iob_eth_rx_ring;
  localparam int AW  = 11;
  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int CAP = 1 << AW;

  logic          clk = 0, rstn = 0, dv = 0, promisc = 0, rel = 0;
  logic [3:0]    rxd = 0;
  logic [47:0]   mac = 48'h001122334455;
  logic [SW+AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          buf_wr, frame_done, frame_crc_ok, frame_err;
  logic [SW-1:0] frame_slot;
  logic [AW:0]   frame_len;
  logic [SW:0]   slots_used;
  logic [15:0]   drop_cnt;

  iob_eth_rx_ring #(.BUF_AW(AW), .NSLOTS(NS)) dut (
    .RX_CLK(clk), .rx_rstn(rstn), .RX_DV(dv), .RX_DATA(rxd), .mac_addr(mac), .promisc(promisc),
    .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr(buf_wr), .frame_done(frame_done),
    .frame_slot(frame_slot), .frame_len(frame_len), .frame_crc_ok(frame_crc_ok),
    .frame_err(frame_err), .release_i(rel), .slots_used(slots_used), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [AW:0]   len;
    logic          ok;
    logic          err;
  } done_t;

  done_t            got_q[$], exp_q[$];
  logic [SW+AW-1:0] wa_q[$];
  logic [7:0]       wd_q[$];
  logic [7:0]       frm[$];
  int total = 0, bad = 0;
  int m_used = 0, m_slot = 0, m_drop = 0;

  always @(negedge clk) begin
    if (buf_wr) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_data);
    end
    if (frame_done) got_q.push_back({frame_slot, frame_len, frame_crc_ok, frame_err});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  // Frame = destination, random body, then FCS (complemented CRC, LSB byte first).
  task automatic build_frame(input logic [47:0] dest, input int body, input bit flip);
    logic [31:0] c;
    int idx;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dest[i*8 +: 8]);
    for (int i = 0; i < body; i++) frm.push_back(8'($urandom));
    c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
    if (flip) begin
      idx = $urandom_range(frm.size() - 1, 6);
      frm[idx] = frm[idx] ^ (8'h1 << $urandom_range(7));
    end
  endtask

  task automatic build_raw(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
  endtask

  task automatic drive_nib(input logic [3:0] n);
    @(posedge clk); #1;
    dv = 1; rxd = n;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    drive_nib(b[3:0]);
    drive_nib(b[7:4]);
  endtask

  // The release pulse, when requested, lands on the cycle the frame would be committed.
  task automatic send(input bit odd, input bit rel_end);
    repeat (7) drive_byte(8'h55);
    drive_byte(8'hD5);
    foreach (frm[i]) drive_byte(frm[i]);
    if (odd) drive_nib(4'($urandom_range(15)));
    @(posedge clk); #1; dv = 0; rxd = 0;
    @(posedge clk); #1; rel = rel_end;
    @(posedge clk); #1; rel = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic model(input bit odd, input bit good, input bit rel_end);
    int n;
    bit dn, rl, bc;
    logic [47:0] d;
    done_t e;
    n = frm.size(); dn = 0; bc = 0;
    if (m_used == NS) m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
    else if (n >= 6) begin
      d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
`ifdef IOB_ETH_RX_BCAST_EN
      bc = d == 48'hFFFFFFFFFFFF;
`endif
      if (d == mac || promisc || bc) begin
        e.slot = SW'(m_slot);
        e.len  = (AW+1)'(n > CAP ? CAP : n);
        e.ok   = good;
        e.err  = odd || n > CAP;
        exp_q.push_back(e);
        m_slot = (m_slot + 1) % NS;
        dn = 1;
      end
    end
    rl = rel_end && m_used > 0;
    m_used = m_used + int'(dn) - int'(rl);
  endtask

  task automatic xfer(input bit odd, input bit good, input bit rel_end);
    model(odd, good, rel_end);
    send(odd, rel_end);
  endtask

  task automatic do_release();
    @(posedge clk); #1; rel = 1;
    @(posedge clk); #1; rel = 0;
    if (m_used > 0) m_used--;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 0; dv = 0; rel = 0; rxd = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    m_used = 0; m_slot = 0; m_drop = 0;
    clear_q();
  endtask

  task automatic test_reset();
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({buf_wr, frame_done, frame_crc_ok, frame_err} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {buf_wr, frame_done, frame_crc_ok, frame_err});
    end
    total++;
    if (buf_addr !== '0 || buf_data !== '0) begin
      bad++; $display("FAIL reset_buf: addr=%0h data=%0h want 0", buf_addr, buf_data);
    end
    total++;
    if (frame_slot !== '0 || frame_len !== '0) begin
      bad++; $display("FAIL reset_status: slot=%0d len=%0d want 0", frame_slot, frame_len);
    end
    total++;
    if (slots_used !== '0 || drop_cnt !== '0) begin
      bad++; $display("FAIL reset_counts: used=%0d drop=%0d want 0", slots_used, drop_cnt);
    end
    @(posedge clk); #1 rstn = 1;
    do_release();
    @(negedge clk);
    total++;
    if (slots_used !== '0) begin
      bad++; $display("FAIL release_empty: used=%0d want 0", slots_used);
    end
    clear_q();
  endtask

  task automatic test_match();
    int n;
    clear_q();
    promisc = 0;
    build_frame(mac, 46, 0);
    n = frm.size();
    xfer(0, 1, 0);
    total++;
    if (got_q.size() != 1 || exp_q[0] !== done_t'({2'd0, 12'd56, 1'b1, 1'b0})) begin
      bad++; $display("FAIL match_count: done=%0d want 1 (slot 0 len 56 ok)", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== exp_q[0]) begin
        bad++;
        $display("FAIL match_rec: got slot=%0d len=%0d ok=%0d err=%0d want slot=%0d len=%0d ok=%0d err=%0d",
                 got_q[0].slot, got_q[0].len, got_q[0].ok, got_q[0].err,
                 exp_q[0].slot, exp_q[0].len, exp_q[0].ok, exp_q[0].err);
      end
    end
    total++;
    if (wa_q.size() != n) begin
      bad++; $display("FAIL match_wr_count: got %0d want %0d", wa_q.size(), n);
    end else
      for (int i = 0; i < n; i++) begin
        total++;
        if (wa_q[i] !== (SW+AW)'(i) || wd_q[i] !== frm[i]) begin
          bad++; $display("FAIL match_wr[%0d]: addr=%0h data=%0h want addr=%0h data=%0h", i, wa_q[i], wd_q[i], i, frm[i]);
        end
      end
    total++;
    if (slots_used !== (SW+1)'(m_used)) begin
      bad++; $display("FAIL match_used: got %0d want %0d", slots_used, m_used);
    end
  endtask

  task automatic test_crc_bad();
    clear_q();
    build_frame(mac, 46, 1);
    xfer(0, 0, 0);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL crc_bad_count: done=%0d want 1", got_q.size());
    end else begin
      total++;
      if (got_q[0].ok !== 1'b0 || got_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL crc_bad_rec: slot=%0d len=%0d ok=%0d want slot=%0d len=%0d ok=0",
                        got_q[0].slot, got_q[0].len, got_q[0].ok, exp_q[0].slot, exp_q[0].len);
      end
    end
  endtask

  task automatic test_mismatch();
    clear_q();
    promisc = 0;
    build_frame(48'h001122334456, 46, 0);
    xfer(0, 1, 0);
    total++;
    if (got_q.size() != 0) begin
      bad++; $display("FAIL mismatch_done: done=%0d want 0", got_q.size());
    end
    total++;
    if (slots_used !== (SW+1)'(m_used) || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL mismatch_counts: used=%0d drop=%0d want used=%0d drop=0", slots_used, drop_cnt, m_used);
    end
  endtask

  task automatic test_ring_full();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      build_frame(mac, $urandom_range(60, 46), 0);
      xfer(0, 1, 0);
    end
    total++;
    if (got_q.size() != 4) begin
      bad++; $display("FAIL full_count: done=%0d want 4", got_q.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i].slot !== SW'(i) || got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL full_slot[%0d]: slot=%0d len=%0d want slot=%0d len=%0d",
                          i, got_q[i].slot, got_q[i].len, i, exp_q[i].len);
        end
      end
    total++;
    if (drop_cnt !== 16'd1 || slots_used !== 3'd4) begin
      bad++; $display("FAIL full_counts: drop=%0d used=%0d want drop=1 used=4", drop_cnt, slots_used);
    end
    do_release();
    @(negedge clk);
    total++;
    if (slots_used !== 3'd3) begin
      bad++; $display("FAIL full_release: used=%0d want 3", slots_used);
    end
    clear_q();
    build_frame(mac, 50, 0);
    xfer(0, 1, 0);
    total++;
    if (got_q.size() != 1 || got_q[0].slot !== '0) begin
      bad++; $display("FAIL full_wrap: done=%0d slot=%0d want 1 frame in slot 0", got_q.size(), got_q.size() ? got_q[0].slot : 'x);
    end
  endtask

  task automatic test_release_at_done();
    do_release();
    do_release();
    @(negedge clk);
    total++;
    if (slots_used !== 3'd2) begin
      bad++; $display("FAIL rel_setup: used=%0d want 2", slots_used);
    end
    clear_q();
    build_frame(mac, 46, 0);
    xfer(0, 1, 1);
    total++;
    if (got_q.size() != 1 || slots_used !== 3'd2 || m_used != 2) begin
      bad++; $display("FAIL rel_at_done: done=%0d used=%0d want done=1 used=2", got_q.size(), slots_used);
    end
  endtask

  task automatic test_odd_nibble();
    clear_q();
    build_frame(mac, $urandom_range(70, 46), 0);
    xfer(1, 1, 0);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL odd_count: done=%0d want 1", got_q.size());
    end else begin
      total++;
      if (got_q[0].err !== 1'b1 || got_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL odd_rec: len=%0d ok=%0d err=%0d want len=%0d ok=%0d err=1",
                        got_q[0].len, got_q[0].ok, got_q[0].err, exp_q[0].len, exp_q[0].ok);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    build_frame(mac, CAP, 0);
    xfer(0, 1, 0);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL ovf_count: done=%0d want 1", got_q.size());
    end else begin
      total++;
      if (got_q[0].len !== (AW+1)'(CAP) || got_q[0] !== exp_q[0]) begin
        bad++; $display("FAIL ovf_rec: len=%0d ok=%0d err=%0d want len=%0d ok=1 err=1",
                        got_q[0].len, got_q[0].ok, got_q[0].err, CAP);
      end
    end
    total++;
    if (wa_q.size() != CAP) begin
      bad++; $display("FAIL ovf_writes: got %0d want %0d", wa_q.size(), CAP);
    end
  endtask

  task automatic test_bcast();
    apply_reset();
    promisc = 0;
    build_frame(48'hFFFFFFFFFFFF, 46, 0);
    xfer(0, 1, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bcast_count: done=%0d want %0d", got_q.size(), exp_q.size());
    end
`ifdef IOB_ETH_RX_BCAST_EN
    total++;
    if (got_q.size() != 1 || slots_used !== 3'd1) begin
      bad++; $display("FAIL bcast_accept: done=%0d used=%0d want 1 1", got_q.size(), slots_used);
    end
`else
    total++;
    if (got_q.size() != 0 || slots_used !== 3'd0) begin
      bad++; $display("FAIL bcast_reject: done=%0d used=%0d want 0 0", got_q.size(), slots_used);
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      int sel;
      bit fl, od, rl;
      logic [47:0] d;
      sel = $urandom_range(9);
      fl  = $urandom_range(3) == 0;
      od  = $urandom_range(4) == 0;
      rl  = $urandom_range(1) == 1;
      d   = sel < 5 ? mac : sel < 7 ? 48'hFFFFFFFFFFFF : {16'($urandom), 32'($urandom)};
      promisc = $urandom_range(3) == 0;
      if ($urandom_range(7) == 0) build_raw($urandom_range(5, 1));
      else build_frame(d, $urandom_range(60), fl);
      xfer(od, !fl, rl);
    end
    promisc = 0;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: done=%0d want %0d", got_q.size(), exp_q.size());
    end else
      foreach (exp_q[i]) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rand_rec[%0d]: slot=%0d len=%0d ok=%0d err=%0d want slot=%0d len=%0d ok=%0d err=%0d",
                   i, got_q[i].slot, got_q[i].len, got_q[i].ok, got_q[i].err,
                   exp_q[i].slot, exp_q[i].len, exp_q[i].ok, exp_q[i].err);
        end
      end
    total++;
    if (slots_used !== (SW+1)'(m_used) || drop_cnt !== 16'(m_drop)) begin
      bad++; $display("FAIL rand_counts: used=%0d drop=%0d want used=%0d drop=%0d", slots_used, drop_cnt, m_used, m_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    build_frame(mac, 46, 0);
    repeat (7) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < 20; i++) drive_byte(frm[i]);
    @(posedge clk); #1 rstn = 0;
    @(negedge clk);
    total++;
    if ({buf_wr, frame_done, frame_crc_ok, frame_err} !== 4'b0 || buf_addr !== '0 || frame_len !== '0
        || slots_used !== '0 || drop_cnt !== '0) begin
      bad++; $display("FAIL midreset_outputs: wr=%0d done=%0d addr=%0h len=%0d used=%0d drop=%0d want all 0",
                      buf_wr, frame_done, buf_addr, frame_len, slots_used, drop_cnt);
    end
    dv = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++;
    if (got_q.size() != 0 || slots_used !== '0) begin
      bad++; $display("FAIL midreset_done: done=%0d used=%0d want 0 0", got_q.size(), slots_used);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_crc_bad();
    test_mismatch();
    test_ring_full();
    test_release_at_done();
    test_odd_nibble();
    test_overflow();
    test_bcast();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
